// File: rtl/lpc_tpm_pattern_trigger.sv
// Watches decoded LPC reads of the TPM data FIFO for a 4-byte pattern and
// pulses trigger for one cycle on each complete match.
module lpc_tpm_pattern_trigger #(
    parameter logic [31:0] PATTERN   = 32'h2C00_0000,
    parameter logic [15:0] FIFO_ADDR = 16'h0024,
    parameter logic [23:0] TIMEOUT   = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_write,
    input  logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        trigger,
    output logic [7:0]  match_count,
    output logic [1:0]  match_idx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_M1   = 2'd1;
    localparam logic [1:0] ST_M2   = 2'd2;
    localparam logic [1:0] ST_M3   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_eff;
    logic [1:0]  state_next;
    logic [23:0] timer;
    logic [23:0] timer_next;
    logic [16:0] addr_off;
    logic        in_window;
    logic        accepted;
    logic        timeout_hit;
    logic [7:0]  expected_byte;
    logic        byte_hit;
    logic        complete;

    // 17-bit offset: addresses below the base wrap to a large value and fall outside.
    assign addr_off  = {1'b0, in_addr} - {1'b0, FIFO_ADDR};
    assign in_window = (addr_off < 17'd4);
    assign accepted  = in_valid && !in_write && in_window;

    // A timeout in the same cycle as an accepted byte wins: the byte is judged from IDLE.
    assign timeout_hit = (state != ST_IDLE) && (timer == TIMEOUT);
    assign state_eff   = timeout_hit ? ST_IDLE : state;

    always_comb begin
        expected_byte = PATTERN[31:24];
        case (state_eff)
            ST_IDLE: expected_byte = PATTERN[31:24];
            ST_M1:   expected_byte = PATTERN[23:16];
            ST_M2:   expected_byte = PATTERN[15:8];
            ST_M3:   expected_byte = PATTERN[7:0];
            default: expected_byte = PATTERN[31:24];
        endcase
    end

    assign byte_hit = (in_data == expected_byte);
    assign complete = accepted && byte_hit && (state_eff == ST_M3);

    always_comb begin
        state_next = state_eff;
        if (accepted) begin
            if (byte_hit) begin
                state_next = complete ? ST_IDLE : state_eff + 2'd1;
            end else if (in_data == PATTERN[31:24]) begin
                state_next = ST_M1;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // Timer measures the gap since the last accepted byte; parked at 0 in IDLE.
    always_comb begin
        timer_next = timer + 24'd1;
        if (accepted || (state_eff == ST_IDLE)) begin
            timer_next = 24'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= 24'd0;
            trigger     <= 1'b0;
            match_count <= 8'd0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            trigger <= complete;
            if (complete && (match_count != 8'hFF)) begin
                match_count <= match_count + 8'd1;
            end
        end
    end

    assign match_idx = state;

endmodule

// File: doc/lpc_tpm_pattern_trigger.md
LPC_TPM_PATTERN_TRIGGER -- requirements
Module: lpc_tpm_pattern_trigger

Interface
REQ-001 Parameter PATTERN, 32'h2C00_0000, byte sequence to match; PATTERN[31:24] is the first byte expected.
REQ-002 Parameter FIFO_ADDR, 16'h0024, base of the TPM data FIFO window; the window is FIFO_ADDR..FIFO_ADDR+3.
REQ-003 Parameter TIMEOUT, 24'd12_000_000, maximum clk cycles allowed between consecutive accepted FIFO bytes of one partial match.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  one-cycle strobe per decoded LPC transaction.
REQ-007 in_write  input  1  transaction direction: 1 = write, 0 = read; qualified by in_valid.
REQ-008 in_addr  input  16  low 16 bits of the TPM memory address; qualified by in_valid.
REQ-009 in_data  input  8  data byte of the transaction; qualified by in_valid.
REQ-010 trigger  output  1  one-cycle pulse on a completed pattern match; drives the LED pulse stretcher.
REQ-011 match_count  output  8  number of completed matches since reset, saturating.
REQ-012 match_idx  output  2  current match progress, 0 to 3, for debug.

Function
REQ-013 An accepted byte SHALL satisfy all of: in_valid=1, in_write=0, and in_addr in FIFO_ADDR..FIFO_ADDR+3.
REQ-014 All other transactions SHALL be ignored: no change to match_idx or the timer, and no break of a partial match.
REQ-015 The state machine SHALL be IDLE (idx=0), then M1, M2, M3 (idx=1..3).
REQ-016 In state idx, an accepted byte equal to PATTERN byte[idx] SHALL advance the state to idx+1.
REQ-017 In M3, an accepted byte equal to PATTERN[7:0] SHALL set trigger=1 in the next cycle for exactly 1 cycle, return to IDLE, and increment match_count.
REQ-018 match_count SHALL saturate at 8'hFF, with no wrap-around.
REQ-019 Mismatch: on an accepted byte not equal to byte[idx], the next state SHALL be M1 if the byte equals PATTERN[31:24], else IDLE.
REQ-020 Timer: a 24-bit counter SHALL clear on every accepted byte and increment each cycle while idx≠0.
REQ-021 When the timer reaches TIMEOUT with idx≠0, the block SHALL go to IDLE and clear the timer; the timer SHALL hold at 0 in IDLE.
REQ-022 Timeout and an accepted byte in the same cycle: the byte SHALL be evaluated against IDLE, i.e. the timeout applies first.
REQ-023 Back-to-back accepted bytes on consecutive cycles SHALL each be processed; there is no throughput limit.
REQ-024 A new match MAY begin in the cycle after a trigger, so consecutive patterns each produce one pulse.
REQ-025 trigger SHALL be registered, with latency exactly 1 cycle from the in_valid of the completing byte.

Reset
REQ-026 While reset=1 at a clk edge: trigger=0, match_count=0, match_idx=0, timer=0; all inputs are ignored.
REQ-027 Reset asserted mid-match SHALL discard the progress; the first cycle after reset deassertion SHALL process inputs normally from IDLE.

Verification
REQ-028 Reads at 0x0024 with data 2C,00,00,00 on consecutive cycles -> trigger=1 in the cycle after the 4th byte only; match_count=1.
REQ-029 Sequence 2C,00,2C,00,00,00 at 0x0025 -> the third byte (2C) restarts at M1; exactly one trigger, after the 6th byte.
REQ-030 2C,00 accepted, then a write of 00 to 0x0024 and a read of 00 from 0x0030, then 00,00 -> both foreign transactions ignored; one trigger.
REQ-031 2C accepted, then TIMEOUT cycles idle, then 00,00,00 -> match_idx returns to 0 at timeout; no trigger.
REQ-032 2C,00,00 accepted, reset pulsed for 1 cycle, then 00 -> no trigger; match_count=0; match_idx=0.
REQ-033 300 complete patterns -> 300 trigger pulses; match_count=8'hFF.
